beep_arbiter: RTL and testbench

Shares the single on-board buzzer between `N_REQ` requesters such as key-click, alarm and timer-expiry sources. Each requester asks for a tone by giving a half-period and a duration. The block grants the buzzer to one requester at a time using fixed priority, generates the square wave for that duration, signals completion, and then enforces a silence gap before the next grant. It sits between the application control logic and the `beep` output pin.

---
 rtl/beep_pkg.sv | 23 ++
 rtl/beep_arbiter_tone_gen.sv | 38 +++
 rtl/beep_arbiter.sv | 163 ++++++++++++++++
 tb/tb_beep_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// beep_pkg: shared types and constants for the buzzer arbiter.
//   state_e          - arbiter FSM states
//   HALF_*           - note half-periods in 50 MHz sys_clk cycles
//   *_DEFAULT        - default block parameters (GAP_CYC = 50 ms at 50 MHz)
package beep_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RING      = 2'd1,
    GAP       = 2'd2,
    ABORT_GAP = 2'd3
  } state_e;

  localparam int unsigned HALF_DO = 95_420;
  localparam int unsigned HALF_RE = 85_034;
  localparam int unsigned HALF_MI = 75_758;

  localparam int unsigned N_REQ_DEFAULT   = 3;
  localparam int unsigned TONE_W_DEFAULT  = 18;
  localparam int unsigned DUR_W_DEFAULT   = 24;
  localparam int unsigned GAP_CYC_DEFAULT = 2_500_000;

endpackage

// File: rtl/beep_arbiter_tone_gen.sv
// tone_gen: square-wave generator toggling every max(half,1) cycles.
//   clk, rst_n - clock, async active-low reset
//   en         - run; counter and wave are cleared while low
//   half       - half-period in clk cycles (0 and 1 both mean 1)
//   wave       - registered square wave, starts low
module tone_gen #(
  parameter int unsigned TONE_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [TONE_W-1:0] half,
  output logic              wave
);

  logic [TONE_W-1:0] cnt_q;
  logic [TONE_W-1:0] term_c;

  // Terminal count; half of 0 or 1 collapses to a toggle every cycle.
  assign term_c = (half <= TONE_W'(1)) ? '0 : half - TONE_W'(1);

  // Half-period counter with toggle on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wave  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      wave  <= 1'b0;
    end else if (cnt_q == term_c) begin
      cnt_q <= '0;
      wave  <= ~wave;
    end else begin
      cnt_q <= cnt_q + TONE_W'(1);
    end
  end

endmodule

// File: rtl/beep_arbiter.sv
// beep_arbiter: fixed-priority sharing of one buzzer between N_REQ requesters.
//   sys_clk, sys_rst_n - clock, async active-low reset
//   req                - level request per requester (index 0 highest priority)
//   req_half           - packed half-periods, slice i = [i*TONE_W +: TONE_W]
//   req_dur            - packed durations,    slice i = [i*DUR_W  +: DUR_W]
//   grant              - one-hot grant while ringing
//   done               - one-cycle completion pulse for the served requester
//   busy               - high whenever not IDLE
//   beep               - buzzer drive
module beep_arbiter
  import beep_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEFAULT,
  parameter int unsigned TONE_W  = TONE_W_DEFAULT,
  parameter int unsigned DUR_W   = DUR_W_DEFAULT,
  parameter int unsigned GAP_CYC = GAP_CYC_DEFAULT
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TONE_W-1:0] req_half,
  input  logic [N_REQ*DUR_W-1:0]  req_dur,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic                    beep
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TONE_W-1:0]   half_q, half_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [N_REQ-1:0]    armed_q, armed_d;
  logic [N_REQ-1:0]    grant_d, done_d;
  logic                busy_d;

  logic [N_REQ-1:0]    elig_c;
  logic                win_found_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic [TONE_W-1:0]   win_half_c;
  logic [DUR_W-1:0]    win_dur_c;
  logic [N_REQ-1:0]    sel_c;
  logic                req_held_c;
  logic                tone_en_c;

  assign elig_c     = req & armed_q;
  assign sel_c      = N_REQ'(1) << idx_q;
  assign req_held_c = |(req & sel_c);

  // Lowest eligible index wins, together with its tone parameters.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_half_c  = '0;
    win_dur_c   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (elig_c[i] && !win_found_c) begin
        win_found_c = 1'b1;
        win_idx_c   = IDX_W'(i);
        win_half_c  = req_half[i*TONE_W +: TONE_W];
        win_dur_c   = req_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  // Next-state and next-output logic; counters idle at zero outside their state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    half_d    = half_q;
    dur_d     = dur_q;
    dur_cnt_d = '0;
    gap_cnt_d = '0;
    grant_d   = '0;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (win_found_c) begin
          idx_d  = win_idx_c;
          half_d = win_half_c;
          dur_d  = win_dur_c;
          // A zero-length tone completes immediately without ever ringing.
          if (win_dur_c == '0) begin
            state_d = GAP;
            done_d  = N_REQ'(1) << win_idx_c;
          end else begin
            state_d = RING;
            grant_d = N_REQ'(1) << win_idx_c;
          end
        end
      end
      RING: begin
        // A dropped request wins over completion: no done for a requester that left.
        if (!req_held_c) begin
          state_d = ABORT_GAP;
        end else if (dur_cnt_q == dur_q - DUR_W'(1)) begin
          state_d = GAP;
          done_d  = sel_c;
        end else begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
          grant_d   = sel_c;
        end
      end
      GAP, ABORT_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Re-arm on any low cycle; disarm on completion so a held request runs once.
    armed_d   = (armed_q & ~done_d) | ~req;
    busy_d    = (state_d != IDLE);
    tone_en_c = (state_q == RING) && (state_d == RING);
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      half_q    <= '0;
      dur_q     <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      armed_q   <= '1;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      half_q    <= half_d;
      dur_q     <= dur_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      armed_q   <= armed_d;
      grant     <= grant_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

  tone_gen #(
    .TONE_W (TONE_W)
  ) u_tone_gen (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .en    (tone_en_c),
    .half  (half_q),
    .wave  (beep)
  );

endmodule

// File: tb/tb_beep_arbiter.sv
// tb_beep_arbiter: directed scenarios for beep_arbiter with a short gap.
// Each cycle compares {grant, done, busy, beep} against a hand-derived vector.
module tb_beep_arbiter;

  localparam int unsigned N_REQ   = 3;
  localparam int unsigned TONE_W  = 18;
  localparam int unsigned DUR_W   = 24;
  localparam int unsigned GAP_CYC = 6;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*TONE_W-1:0] req_half;
  logic [N_REQ*DUR_W-1:0]  req_dur;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    busy;
  logic                    beep;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  beep_arbiter #(
    .N_REQ   (N_REQ),
    .TONE_W  (TONE_W),
    .DUR_W   (DUR_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .req       (req),
    .req_half  (req_half),
    .req_dur   (req_dur),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .beep      (beep)
  );

  task automatic set_tone(input int i, input int h, input int d);
    req_half[i*TONE_W +: TONE_W] = TONE_W'(h);
    req_dur[i*DUR_W +: DUR_W]    = DUR_W'(d);
  endtask

  // Beep level in ringing cycle c (1-based) for half-period h.
  function automatic logic exp_beep(input int c, input int h);
    int hh;
    hh = (h < 2) ? 1 : h;
    return 1'(((c - 1) / hh) % 2);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({grant, done, busy, beep} !== 8'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", {grant, done, busy, beep}, 8'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant, done, busy, beep} !== 8'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=%b", {grant, done, busy, beep}, 8'b0);
    end
  endtask

  // req[1], half=4, dur=20, held high throughout: served once only.
  task automatic test_single();
    logic [7:0] expv;
    set_tone(1, 4, 20);
    @(negedge clk);
    req = 3'b010;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      expv = {(c <= 20) ? 3'b010 : 3'b000,
              (c == 21) ? 3'b010 : 3'b000,
              (c <= 26),
              (c <= 20) ? exp_beep(c, 4) : 1'b0};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL single c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
    end
    req = 3'b000;
  endtask

  // req[0] and req[2] together: 0 first, 2 granted GAP_CYC+1 cycles after done[0].
  task automatic test_contention();
    logic [7:0] expv;
    logic [2:0] g;
    logic [2:0] d;
    logic       b;
    logic       bp;
    set_tone(0, 3, 5);
    set_tone(2, 2, 4);
    @(negedge clk);
    req = 3'b101;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      g  = (c <= 5) ? 3'b001 : ((c >= 13 && c <= 16) ? 3'b100 : 3'b000);
      d  = (c == 6) ? 3'b001 : ((c == 17) ? 3'b100 : 3'b000);
      b  = (c <= 11) || (c >= 13 && c <= 22);
      bp = (c <= 5) ? exp_beep(c, 3) : ((c >= 13 && c <= 16) ? exp_beep(c - 12, 2) : 1'b0);
      expv = {g, d, b, bp};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL contention c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
    end
    req = 3'b000;
  endtask

  // req[0] held past done: re-served only after a low cycle.
  task automatic test_held();
    logic [7:0] expv;
    logic [2:0] g;
    logic       bp;
    set_tone(0, 2, 3);
    @(negedge clk);
    req = 3'b001;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      g  = ((c <= 3) || (c >= 17 && c <= 19)) ? 3'b001 : 3'b000;
      bp = (c <= 3) ? exp_beep(c, 2) : ((c >= 17 && c <= 19) ? exp_beep(c - 16, 2) : 1'b0);
      expv = {g, (c == 4 || c == 20) ? 3'b001 : 3'b000,
              (c <= 9) || (c >= 17 && c <= 25), bp};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL held c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
      if (c == 15) req = 3'b000;
      if (c == 16) req = 3'b001;
      if (c == 21) req = 3'b000;
    end
  endtask

  // req[1] dropped in ringing cycle 7 while beep is high.
  task automatic test_abort();
    logic [7:0] expv;
    set_tone(1, 4, 30);
    @(negedge clk);
    req = 3'b010;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      expv = {(c <= 7) ? 3'b010 : 3'b000, 3'b000, (c <= 13),
              (c <= 7) ? exp_beep(c, 4) : 1'b0};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL abort c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
      if (c == 7) req = 3'b000;
    end
  endtask

  // dur=0 skips ringing; half=0 toggles every cycle.
  task automatic test_edges();
    logic [7:0] expv;
    set_tone(2, 5, 0);
    @(negedge clk);
    req = 3'b100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      expv = {3'b000, (c == 1) ? 3'b100 : 3'b000, (c <= 6), 1'b0};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL dur0 c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
    end
    req = 3'b000;
    set_tone(0, 0, 6);
    @(negedge clk);
    req = 3'b001;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      expv = {(c <= 6) ? 3'b001 : 3'b000, (c == 7) ? 3'b001 : 3'b000, (c <= 12),
              (c <= 6) ? exp_beep(c, 0) : 1'b0};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL half0 c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
    end
    req = 3'b000;
  endtask

  // Asynchronous reset mid-ring, then a fresh request served normally.
  task automatic test_reset_mid();
    logic [7:0] expv;
    set_tone(1, 2, 40);
    @(negedge clk);
    req = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      expv = {3'b010, 3'b000, 1'b1, exp_beep(c, 2)};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL pre_reset c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
    end
    rst_n = 1'b0;
    req   = 3'b000;
    #1;
    checks++;
    if ({grant, done, busy, beep} !== 8'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", {grant, done, busy, beep}, 8'b0);
    end
    #1;
    rst_n = 1'b1;
    set_tone(1, 1, 3);
    @(negedge clk);
    req = 3'b010;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      expv = {(c <= 3) ? 3'b010 : 3'b000, (c == 4) ? 3'b010 : 3'b000, (c <= 9),
              (c <= 3) ? exp_beep(c, 1) : 1'b0};
      checks++;
      if ({grant, done, busy, beep} !== expv) begin
        errors++;
        $display("FAIL post_reset c=%0d got=%b exp=%b", c, {grant, done, busy, beep}, expv);
      end
      if (c == 5) req = 3'b000;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_half = '0;
    req_dur  = '0;
    test_reset();
    test_single();
    test_contention();
    test_held();
    test_abort();
    test_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before completion");
    $fatal(1);
  end

endmodule
